// File: rtl/rect_draw_engine.sv
// Rectangle rasteriser: latches a draw command and walks its pixels row-major,
// in filled or outline-only mode, honouring sink back-pressure.
module rect_draw_engine #(
  parameter int XW = 8,
  parameter int YW = 7,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [XW-1:0] x0,
  input  logic [YW-1:0] y0,
  input  logic [XW-1:0] rect_w,
  input  logic [YW-1:0] rect_h,
  input  logic [CW-1:0] colour_in,
  input  logic          outline,
  input  logic          pix_ready,
  output logic          plot,
  output logic [XW-1:0] x_out,
  output logic [YW-1:0] y_out,
  output logic [CW-1:0] colour_out,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, DRAW, FIN} state_t;

  localparam logic [XW-1:0] ONE_X = XW'(1);
  localparam logic [YW-1:0] ONE_Y = YW'(1);

  state_t        state, state_nxt;
  logic [XW-1:0] x0_r, w_r, col, col_nxt, w_m1;
  logic [YW-1:0] y0_r, h_r, row, row_nxt, h_m1;
  logic [CW-1:0] colour_r;
  logic          outline_r;
  logic          last_col, last_row, interior_row;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      x0_r      <= '0;
      y0_r      <= '0;
      w_r       <= '0;
      h_r       <= '0;
      colour_r  <= '0;
      outline_r <= 1'b0;
    end else begin
      state <= state_nxt;
      col   <= col_nxt;
      row   <= row_nxt;
      if (state == IDLE && start) begin
        x0_r      <= x0;
        y0_r      <= y0;
        w_r       <= rect_w;
        h_r       <= rect_h;
        colour_r  <= colour_in;
        outline_r <= outline;
      end
    end
  end

  // Only evaluated in DRAW, where the latched size is known to be non-zero.
  assign w_m1         = w_r - ONE_X;
  assign h_m1         = h_r - ONE_Y;
  assign last_col     = (col == w_m1);
  assign last_row     = (row == h_m1);
  assign interior_row = outline_r && (row != '0) && !last_row;

  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    row_nxt   = row;
    plot      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          col_nxt   = '0;
          row_nxt   = '0;
          state_nxt = (rect_w != '0 && rect_h != '0) ? DRAW : FIN;
        end
      end
      DRAW: begin
        plot = 1'b1;
        busy = 1'b1;
        if (pix_ready) begin
          // Interior outline rows visit only the left and right edge columns.
          if (interior_row) begin
            if (col == '0 && !last_col) begin
              col_nxt = w_m1;
            end else begin
              col_nxt = '0;
              row_nxt = row + ONE_Y;
            end
          end else if (!last_col) begin
            col_nxt = col + ONE_X;
          end else if (last_row) begin
            state_nxt = FIN;
          end else begin
            col_nxt = '0;
            row_nxt = row + ONE_Y;
          end
        end
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign x_out      = plot ? (x0_r + col) : '0;
  assign y_out      = plot ? (y0_r + row) : '0;
  assign colour_out = plot ? colour_r : '0;

endmodule

// File: tb/tb_rect_draw_engine.sv
// Randomised self-checking bench for rect_draw_engine against a pixel-list
// reference model built directly from the rectangle geometry.
module tb_rect_draw_engine;

  localparam int XW = 8;
  localparam int YW = 7;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [XW-1:0] x0;
  logic [YW-1:0] y0;
  logic [XW-1:0] rect_w;
  logic [YW-1:0] rect_h;
  logic [CW-1:0] colour_in;
  logic          outline;
  logic          pix_ready;
  logic          plot;
  logic [XW-1:0] x_out;
  logic [YW-1:0] y_out;
  logic [CW-1:0] colour_out;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;
  int exp_x[$];
  int exp_y[$];

  rect_draw_engine #(.XW(XW), .YW(YW), .CW(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .x0(x0), .y0(y0),
    .rect_w(rect_w), .rect_h(rect_h), .colour_in(colour_in), .outline(outline),
    .pix_ready(pix_ready), .plot(plot), .x_out(x_out), .y_out(y_out),
    .colour_out(colour_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  // Every pixel of the rectangle that lies on the border (or all of them when filled).
  task automatic buildModel(input int x, input int y, input int w, input int h, input bit ol);
    exp_x.delete();
    exp_y.delete();
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        if (!ol || r == 0 || r == h - 1 || c == 0 || c == w - 1) begin
          exp_x.push_back((x + c) % (1 << XW));
          exp_y.push_back((y + r) % (1 << YW));
        end
  endtask

  // rmode: 0 = sink always ready, 1 = random stalls, 2 = stalled for the first 3 cycles
  task automatic applyStimulus(input int x, input int y, input int w, input int h,
                               input int c, input bit ol, input int rmode);
    int  cyc;
    int  budget;
    bit  rdy;
    buildModel(x, y, w, h, ol);
    budget = 4 * exp_x.size() + 20;
    @(negedge clk);
    start     = 1'b1;
    x0        = XW'(x);
    y0        = YW'(y);
    rect_w    = XW'(w);
    rect_h    = YW'(h);
    colour_in = CW'(c);
    outline   = ol;
    @(negedge clk);
    start = 1'b0;
    cyc   = 0;
    while (exp_x.size() > 0 && cyc < budget) begin
      case (rmode)
        0:       rdy = 1'b1;
        2:       rdy = (cyc >= 3);
        default: rdy = ($urandom_range(3) != 0);
      endcase
      pix_ready = rdy;
      // Junk commands while busy must not be latched.
      start     = 1'($urandom_range(1));
      x0        = XW'($urandom);
      y0        = YW'($urandom);
      rect_w    = XW'($urandom);
      rect_h    = YW'($urandom);
      colour_in = CW'($urandom);
      outline   = 1'($urandom_range(1));
      checkOutput("plot", 32'(plot), 1);
      checkOutput("busy", 32'(busy), 1);
      checkOutput("done_early", 32'(done), 0);
      checkOutput("x_out", 32'(x_out), 32'(exp_x[0]));
      checkOutput("y_out", 32'(y_out), 32'(exp_y[0]));
      checkOutput("colour_out", 32'(colour_out), 32'(c % (1 << CW)));
      if (rdy) begin
        void'(exp_x.pop_front());
        void'(exp_y.pop_front());
      end
      cyc++;
      @(negedge clk);
    end
    checkOutput("budget_left", 32'(exp_x.size()), 0);
    checkOutput("done_pulse", 32'(done), 1);
    checkOutput("plot_fin", 32'(plot), 0);
    checkOutput("busy_fin", 32'(busy), 0);
    start = 1'($urandom_range(1));
    @(negedge clk);
    start = 1'b0;
    checkOutput("done_clear", 32'(done), 0);
    checkOutput("busy_idle", 32'(busy), 0);
    checkOutput("plot_idle", 32'(plot), 0);
  endtask

  task automatic resetMidDraw();
    @(negedge clk);
    start = 1'b1; x0 = 8'd5; y0 = 7'd5; rect_w = 8'd8; rect_h = 7'd8;
    colour_in = 3'd6; outline = 1'b0; pix_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("plot_before_reset", 32'(plot), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("plot_after_reset", 32'(plot), 0);
    checkOutput("busy_after_reset", 32'(busy), 0);
    checkOutput("done_after_reset", 32'(done), 0);
    checkOutput("x_after_reset", 32'(x_out), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("no_done_after_abort", 32'(done), 0);
      checkOutput("idle_after_abort", 32'(busy), 0);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; x0 = '0; y0 = '0; rect_w = '0; rect_h = '0;
    colour_in = '0; outline = 1'b0; pix_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checkOutput("reset_plot", 32'(plot), 0);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_done", 32'(done), 0);
    checkOutput("reset_x", 32'(x_out), 0);
    checkOutput("reset_y", 32'(y_out), 0);
    checkOutput("reset_colour", 32'(colour_out), 0);

    applyStimulus(10, 20, 3, 2, 5, 1'b0, 0);
    applyStimulus(0, 0, 4, 4, 3, 1'b1, 0);
    applyStimulus(7, 9, 2, 1, 1, 1'b0, 2);
    applyStimulus(1, 1, 0, 5, 2, 1'b0, 0);
    applyStimulus(1, 1, 5, 0, 2, 1'b1, 0);
    applyStimulus(254, 3, 4, 1, 7, 1'b0, 0);
    applyStimulus(250, 125, 6, 5, 4, 1'b1, 1);
    applyStimulus(20, 20, 1, 6, 2, 1'b1, 1);
    applyStimulus(30, 30, 5, 2, 2, 1'b1, 1);
    resetMidDraw();

    for (int n = 0; n < 40; n++) begin
      applyStimulus(int'($urandom_range(255)), int'($urandom_range(127)),
                    int'($urandom_range(10)), int'($urandom_range(8)),
                    int'($urandom_range(7)), 1'($urandom_range(1)),
                    int'($urandom_range(2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rect_draw_engine.md
Name: rect_draw_engine

Overview:
- Parametrised rectangle rasteriser feeding the VGA pixel-write path.
- Accepts a start command with origin, size, colour and mode, then emits one pixel coordinate per accepted cycle, row-major, top-left first.
- Supports filled or outline-only drawing, back-pressure from the pixel sink, and a one-cycle done pulse.
- Used by game-object draw sequencers; replaces free-running, non-restartable rectangle counters.

Parameters:
XW, 8, width of x coordinates and of rectangle width.
YW, 7, width of y coordinates and of rectangle height.
CW, 3, colour width.

Ports:
clk  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  command strobe; sampled only in IDLE.
x0  in  XW  left column of rectangle.
y0  in  YW  top row of rectangle.
rect_w  in  XW  width in pixels (0 = empty).
rect_h  in  YW  height in pixels (0 = empty).
colour_in  in  CW  pixel colour.
outline  in  1  1 = border only, 0 = filled.
pix_ready  in  1  sink accepts the presented pixel this cycle.
plot  out  1  x_out/y_out/colour_out valid.
x_out  out  XW  pixel column.
y_out  out  YW  pixel row.
colour_out  out  CW  pixel colour.
busy  out  1  command in progress.
done  out  1  one-cycle pulse when command completes.

Behaviour:
- Reset: state IDLE; plot=0, busy=0, done=0; x_out, y_out, colour_out = 0; internal col/row counters = 0. Reset mid-draw aborts with no done pulse.
- States: IDLE, DRAW, FIN.
- IDLE:
  - start=1 latches x0, y0, rect_w, rect_h, colour_in and outline.
  - Clears col and row to 0.
  - Next state is DRAW if rect_w!=0 and rect_h!=0; otherwise FIN.
  - busy rises in the cycle after start.
- DRAW:
  - plot=1 every cycle.
  - x_out = x0+col and y_out = y0+row, both modulo 2^XW / 2^YW (wrap, no saturation).
  - colour_out = latched colour.
  - Outputs are held stable while pix_ready=0.
  - Advance occurs only when plot and pix_ready are both 1.
- Advance, fill mode:
  - col<rect_w-1: col+1.
  - Otherwise: col=0, row+1.
  - Last pixel is (rect_w-1, rect_h-1).
- Advance, outline mode:
  - On row 0 and row rect_h-1, behaves as fill.
  - On interior rows, col jumps 0 -> rect_w-1, then to col 0 of the next row.
  - rect_w=1 gives a single column, with no duplicate pixel.
  - rect_h<=2 degenerates to fill.
- Pixel count:
  - Fill: W*H.
  - Outline: W*H if W<=2 or H<=2; otherwise 2W+2(H-2).
  - No pixel is ever emitted twice.
- Last pixel accepted -> FIN. plot=0 in FIN.
- FIN: done=1 for exactly one cycle, busy=0 in that cycle, then IDLE.
- Empty rectangle: start at cycle N gives done at N+1, with plot never asserted.
- Latency: start sampled at edge N gives the first plot valid in cycle N+1.
- start while busy or in FIN is ignored; it is not queued.
- Arithmetic: counters are XW/YW wide. Comparisons against rect_w-1 / rect_h-1 are done only after the zero check, so there is no underflow.
- Throughput: with pix_ready held high, one pixel per cycle; a WxH fill takes W*H+2 cycles from start to done.

Test Plan:
- Fill 3x2 at (10,20), pix_ready=1 -> plot for 6 cycles: (10,20),(11,20),(12,20),(10,21),(11,21),(12,21); done 1 cycle later; busy low in done cycle.
- Outline 4x4 at (0,0) -> 12 pixels in order: row0 x0..3; rows 1,2 x0 then x3; row3 x0..3. No interior (1,1),(2,2).
- Back-pressure: fill 2x1, pix_ready low for 3 cycles on first pixel -> (x0,y0) held 4 cycles, then next pixel, then done; total pixels 2.
- Zero size: rect_w=0, rect_h=5, start -> no plot, done pulses the next cycle; then rect_w=5, rect_h=0 -> same.
- Wrap: x0=254, rect_w=4, rect_h=1, XW=8 -> x_out 254,255,0,1; y constant.
- Reset/restart: reset asserted mid-draw of 8x8 -> next cycle plot=0, busy=0, no done. A start pulsed during busy of another command -> ignored; pixel count unchanged.
